// File: rtl/mx_pkg.sv
// mx_pkg: shared E4M3/E8M0 constants, FSM states and msb helper for MX quantisation
package mx_pkg;
  typedef logic [7:0] fp8_t;
  typedef enum logic [1:0] {FILL, SCALE, DRAIN} state_t;
  localparam int E4M3_BIAS = 7;
  localparam int E4M3_EMAX = 8;
  localparam int E4M3_MANT = 3;
  localparam fp8_t E4M3_MAX = 8'h7E;
  localparam fp8_t E4M3_NAN = 8'h7F;
  localparam int E8M0_BIAS = 127;
  function automatic int msb_idx(input logic [63:0] v);
    int r;
    r = 0;
    for (int i = 0; i < 64; i++) if (v[i]) r = i;
    return r;
  endfunction
endpackage

// File: rtl/fp8_e4m3_enc.sv
// fp8_e4m3_enc: scales a fixed-point value by the shared exponent and rounds it to E4M3
import mx_pkg::*;
module fp8_e4m3_enc #(
  parameter int in_width = 43,
  parameter int frac_width = 18
) (
  input  logic [in_width-1:0] x,
  input  logic                nan,
  input  logic signed [8:0]   shared_exp,
  output fp8_t                elem
);
  logic signed [in_width:0] sx;
  logic [63:0] mag, r, rem, half, code;
  int p, sh, top, qpos;
  // quantum position is fixed by the element exponent, floored at the subnormal exponent;
  // code = (biased exp - 1) * 8 + rounded significand, so mantissa carry and subnormals fall out naturally
  always_comb begin
    sx = {x[in_width-1], x};
    mag = 64'(sx[in_width] ? -sx : sx);
    p = msb_idx(mag);
    sh = frac_width + int'(shared_exp);
    top = p > sh + 1 - E4M3_BIAS ? p : sh + 1 - E4M3_BIAS;
    qpos = top - E4M3_MANT;
    rem = '0;
    half = '0;
    if (qpos <= 0) r = mag << (-qpos);
    else if (qpos >= 64) r = '0;
    else begin
      r = mag >> qpos;
      rem = mag & ((64'd1 << qpos) - 64'd1);
      half = 64'd1 << (qpos - 1);
      r = r + 64'((rem > half) || (rem == half && r[0]));
    end
    code = 64'(top - sh + E4M3_BIAS - 1) * 64'd8 + r;
    elem = nan ? E4M3_NAN : {x[in_width-1], code > 64'(E4M3_MAX) ? E4M3_MAX[6:0] : code[6:0]};
  end
endmodule

// File: rtl/mx_quant_fp8.sv
// mx_quant_fp8: buffers k fixed-point values, derives an E8M0 scale and streams E4M3 elements
import mx_pkg::*;
module mx_quant_fp8 #(
  parameter int in_width = 43,
  parameter int frac_width = 18,
  parameter int k = 32,
  parameter int elem_emax = E4M3_EMAX
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_valid,
  output logic                i_ready,
  input  logic [in_width-1:0] i_data,
  input  logic                i_nan,
  output logic                o_valid,
  input  logic                o_ready,
  output fp8_t                o_elem,
  output logic [7:0]          o_scale,
  output logic                o_last
);
  localparam int CW = $clog2(k);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [in_width:0] buffer [k];
  logic [in_width:0] max_abs, abs_in;
  logic signed [in_width:0] sx;
  logic [7:0] scale_n;
  logic signed [8:0] shared_exp;
  logic in_hs, out_hs, last_cnt;
  fp8_t enc;
  int msb, code;
  fp8_e4m3_enc #(.in_width(in_width), .frac_width(frac_width)) u_enc (
    .x(buffer[cnt][in_width-1:0]),
    .nan(buffer[cnt][in_width]),
    .shared_exp(shared_exp),
    .elem(enc)
  );
  // next state, handshakes, outputs and the scale candidate from the running max
  always_comb begin
    i_ready = state == FILL;
    o_valid = state == DRAIN;
    last_cnt = cnt == CW'(k - 1);
    in_hs = i_valid && i_ready;
    out_hs = o_valid && o_ready;
    o_last = o_valid && last_cnt;
    o_elem = o_valid ? enc : '0;
    state_n = (state == FILL && in_hs && last_cnt) ? SCALE :
              (state == SCALE) ? DRAIN :
              (state == DRAIN && out_hs && last_cnt) ? FILL : state;
    sx = {i_data[in_width-1], i_data};
    abs_in = sx[in_width] ? -sx : sx;
    msb = msb_idx(64'(max_abs));
    code = msb - frac_width - elem_emax + E8M0_BIAS;
    scale_n = max_abs == '0 ? 8'(E8M0_BIAS) : code < 0 ? 8'd0 : code > 254 ? 8'd254 : 8'(code);
    shared_exp = $signed({1'b0, o_scale}) - 9'sd127;
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else state <= state_n;
  end
  // element storage as {nan, data}
  always_ff @(posedge clk) begin
    if (state == FILL && in_hs) buffer[cnt] <= {i_nan, i_data};
  end
  // shared counter for fill and drain, running max of finite magnitudes, scale register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      max_abs <= '0;
      o_scale <= '0;
    end else if (state == FILL && in_hs) begin
      cnt <= last_cnt ? '0 : cnt + 1'b1;
      if (!i_nan && abs_in > max_abs) max_abs <= abs_in;
    end else if (state == SCALE) begin
      o_scale <= scale_n;
    end else if (state == DRAIN && out_hs) begin
      cnt <= last_cnt ? '0 : cnt + 1'b1;
      if (last_cnt) max_abs <= '0;
    end
  end
endmodule
